// File: rtl/val2_shifter_seq.sv
// val2_shifter_seq: multi-cycle Val2 / shifter-operand unit with valid/ready handshakes on both sides.
// Optional feature macro VAL2_REG_SHIFT_EN enables register-amount shifts (rs_val[7:0]).
module val2_shifter_seq #(
    parameter int DATA_W = 32,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_operand_in,
    input  logic [DATA_W-1:0] i_rs_val,
    input  logic [11:0]       i_shift_operand,
    input  logic              i_is_immediate,
    input  logic              i_sign_extend,
    input  logic              i_shift_by_reg,
    input  logic              i_carry_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_operand_out,
    output logic              o_carry_out
);
    localparam int RW = $clog2(DATA_W) + 1;
    localparam int SW = $clog2(STEP) + 1;
    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_cout;
    logic              r_kill;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_result;
    logic [RW-1:0]     r_rem;
    logic [1:0]        r_type;

    logic [DATA_W-1:0] w_init_data;
    logic              w_init_carry;
    logic [RW-1:0]     w_init_rem;
    logic [1:0]        w_init_type;
    logic              w_init_kill;
    logic [4:0]        w_imm_amt;
    logic [1:0]        w_sh;

`ifdef VAL2_REG_SHIFT_EN
    logic [7:0]        w_reg_amt;
    logic              w_unused;
    assign w_reg_amt = i_rs_val[7:0];
    assign w_unused  = ^{i_rs_val[DATA_W-1:8], i_shift_operand[4]};
`else
    logic              w_unused;
    assign w_unused  = ^{i_rs_val, i_shift_by_reg, i_shift_operand[4]};
`endif

    // Decode the request into a starting value plus a remaining amount; zero-amount cases finish here.
    always_comb begin
        w_imm_amt    = i_shift_operand[11:7];
        w_sh         = i_shift_operand[6:5];
        w_init_data  = i_operand_in;
        w_init_carry = i_carry_in;
        w_init_rem   = '0;
        w_init_type  = w_sh;
        w_init_kill  = 1'b0;
        if (i_sign_extend) begin
            w_init_data = {{(DATA_W-12){i_shift_operand[11]}}, i_shift_operand};
        end else if (i_is_immediate) begin
            w_init_data = {{(DATA_W-8){1'b0}}, i_shift_operand[7:0]};
            w_init_rem  = RW'({i_shift_operand[11:8], 1'b0});
            w_init_type = SH_ROR;
`ifdef VAL2_REG_SHIFT_EN
        end else if (i_shift_by_reg) begin
            if (w_reg_amt != 8'd0) begin
                if (w_sh == SH_ROR) begin
                    w_init_rem = RW'(int'(w_reg_amt) % DATA_W);
                    if (w_init_rem == '0) begin
                        w_init_carry = i_operand_in[DATA_W-1];
                    end
                end else if (int'(w_reg_amt) >= DATA_W) begin
                    w_init_rem  = RW'(DATA_W);
                    w_init_kill = (w_sh != SH_ASR) && (int'(w_reg_amt) > DATA_W);
                end else begin
                    w_init_rem = RW'(w_reg_amt);
                end
            end
`endif
        end else if (w_imm_amt != 5'd0) begin
            w_init_rem = RW'(w_imm_amt);
        end else if (w_sh == SH_LSR || w_sh == SH_ASR) begin
            w_init_rem = RW'(DATA_W);
        end else if (w_sh == SH_ROR) begin
            w_init_data  = {i_carry_in, i_operand_in[DATA_W-1:1]};
            w_init_carry = i_operand_in[0];
        end
    end

    logic [SW-1:0]     w_s;
    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr;
    logic [DATA_W-1:0] w_ror;
    logic [DATA_W-1:0] w_next_data;
    logic              w_next_carry;
    logic              w_last;

    // One bounded step; the extra bit in each shift captures the last bit shifted out.
    always_comb begin
        w_s   = (r_rem > RW'(STEP)) ? SW'(STEP) : SW'(r_rem);
        w_lsl = {1'b0, r_data} << w_s;
        w_lsr = {r_data, 1'b0} >> w_s;
        w_asr = $signed({r_data, 1'b0}) >>> w_s;
        w_ror = (r_data >> w_s) | (r_data << (RW'(DATA_W) - RW'(w_s)));
        w_next_data  = r_data;
        w_next_carry = 1'b0;
        case (r_type)
            SH_LSL: begin
                w_next_data  = w_lsl[DATA_W-1:0];
                w_next_carry = w_lsl[DATA_W];
            end
            SH_LSR: begin
                w_next_data  = w_lsr[DATA_W:1];
                w_next_carry = w_lsr[0];
            end
            SH_ASR: begin
                w_next_data  = w_asr[DATA_W:1];
                w_next_carry = w_asr[0];
            end
            SH_ROR: begin
                w_next_data  = w_ror;
                w_next_carry = w_ror[DATA_W-1];
            end
        endcase
        w_last = (r_rem <= RW'(STEP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_kill      <= 1'b0;
            r_data      <= '0;
            r_result    <= '0;
            r_rem       <= '0;
            r_type      <= '0;
        end else if (i_flush) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_data     <= w_init_data;
                        r_rem      <= w_init_rem;
                        r_type     <= w_init_type;
                        r_kill     <= w_init_kill;
                        r_in_ready <= 1'b0;
                        if (w_init_rem == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_init_data;
                            r_cout      <= w_init_carry;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_data <= w_next_data;
                    r_rem  <= r_rem - RW'(w_s);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_next_data;
                        r_cout      <= w_next_carry & ~r_kill;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_operand_out = r_result;
    assign o_carry_out   = r_cout;
endmodule

// File: tb/tb_val2_shifter_seq.sv
// tb_val2_shifter_seq: scoreboard bench for val2_shifter_seq at DATA_W=32, STEP=8.
// The reference model honours VAL2_REG_SHIFT_EN the same way the design build does.
module tb_val2_shifter_seq;
    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] operandIn;
    logic [31:0] rsVal;
    logic [11:0] shiftOperand;
    logic        isImmediate;
    logic        signExtend;
    logic        shiftByReg;
    logic        carryIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] operandOut;
    logic        carryOut;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        int          lat;
    } expT;

    expT         sbQueue[$];
    expT         pend;
    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] holdRes;
    logic        holdCarry;
    logic [1:0]  randSel;
    logic [31:0] randRs;

    always #5 clk = ~clk;

    val2_shifter_seq #(.DATA_W(32), .STEP(8)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .i_flush        (flush),
        .i_in_valid     (inValid),
        .o_in_ready     (inReady),
        .i_operand_in   (operandIn),
        .i_rs_val       (rsVal),
        .i_shift_operand(shiftOperand),
        .i_is_immediate (isImmediate),
        .i_sign_extend  (signExtend),
        .i_shift_by_reg (shiftByReg),
        .i_carry_in     (carryIn),
        .o_out_valid    (outValid),
        .i_out_ready    (outReady),
        .o_operand_out  (operandOut),
        .o_carry_out    (carryOut)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Direct (non-iterative) model of Val2, carry and latency 1+ceil(E/8).
    function automatic void refVal2(input logic [31:0] op, input logic [31:0] rs, input logic [11:0] imm,
                                    input logic isImm, input logic sx, input logic byReg, input logic cin,
                                    output logic [31:0] res, output logic c, output int lat);
        int k;
        int e;
        logic rrx;
        logic byR;
        logic [1:0] t;
        logic [31:0] v;
        t = imm[6:5];
`ifdef VAL2_REG_SHIFT_EN
        byR = byReg;
`else
        byR = 1'b0;
`endif
        e = 0;
        res = op;
        c = cin;
        rrx = 1'b0;
        if (sx) begin
            res = {{20{imm[11]}}, imm};
        end else if (isImm) begin
            k = 2 * int'(imm[11:8]);
            v = {24'b0, imm[7:0]};
            res = v;
            if (k != 0) begin
                res = (v >> k) | (v << (32 - k));
                c = res[31];
            end
            e = k;
        end else begin
            if (byR) begin
                k = int'(rs[7:0]);
            end else begin
                k = int'(imm[11:7]);
                if (k == 0 && (t == 2'd1 || t == 2'd2)) k = 32;
                if (k == 0 && t == 2'd3) rrx = 1'b1;
            end
            if (rrx) begin
                res = {cin, op[31:1]};
                c = op[0];
            end else if (k != 0) begin
                case (t)
                    2'd0: begin
                        e = (k > 32) ? 32 : k;
                        if (k < 32) begin res = op << k; c = op[32-k]; end
                        else begin res = 32'h0; c = (k == 32) ? op[0] : 1'b0; end
                    end
                    2'd1: begin
                        e = (k > 32) ? 32 : k;
                        if (k < 32) begin res = op >> k; c = op[k-1]; end
                        else begin res = 32'h0; c = (k == 32) ? op[31] : 1'b0; end
                    end
                    2'd2: begin
                        e = (k > 32) ? 32 : k;
                        if (k < 32) begin res = 32'($signed(op) >>> k); c = op[k-1]; end
                        else begin res = {32{op[31]}}; c = op[31]; end
                    end
                    default: begin
                        e = k % 32;
                        if (e == 0) c = op[31];
                        else begin res = (op >> e) | (op << (32 - e)); c = res[31]; end
                    end
                endcase
            end
        end
        lat = 1 + (e + 7) / 8;
    endfunction

    task automatic applyStimulus(input logic [31:0] op, input logic [31:0] rs, input logic [11:0] imm,
                                 input logic isImm, input logic sx, input logic byReg, input logic cin);
        expT e;
        int guard;
        @(negedge clk);
        operandIn = op;
        rsVal = rs;
        shiftOperand = imm;
        isImmediate = isImm;
        signExtend = sx;
        shiftByReg = byReg;
        carryIn = cin;
        inValid = 1'b1;
        guard = 0;
        while (!inReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptReady", inReady, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        refVal2(op, rs, imm, isImm, sx, byReg, cin, e.res, e.cout, e.lat);
        sbQueue.push_back(e);
    endtask

    task automatic collectResult(input int holdCycles, input bit doHandoff);
        expT e;
        int lat;
        lat = 1;
        while (!outValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("sbDepth", 32'(sbQueue.size()), 1);
        if (sbQueue.size() == 0) return;
        e = sbQueue.pop_front();
        checkOutput("latency", lat, e.lat);
        checkOutput("result", operandOut, e.res);
        checkOutput("carry", carryOut, e.cout);
        holdRes = operandOut;
        holdCarry = carryOut;
        repeat (holdCycles) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", outValid, 1);
            checkOutput("holdResult", operandOut, e.res);
            checkOutput("holdCarry", carryOut, e.cout);
            checkOutput("holdReady", inReady, 0);
        end
        if (doHandoff) begin
            outReady = 1'b1;
            @(posedge clk);
            #1;
            outReady = 1'b0;
            checkOutput("handoff", outValid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0;
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        operandIn = '0;
        rsVal = '0;
        shiftOperand = '0;
        isImmediate = 1'b0;
        signExtend = 1'b0;
        shiftByReg = 1'b0;
        carryIn = 1'b0;
        #12;
        checkOutput("rstReady", inReady, 0);
        checkOutput("rstValid", outValid, 0);
        checkOutput("rstResult", operandOut, 0);
        checkOutput("rstCarry", carryOut, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstReady", inReady, 1);

        applyStimulus(32'h0, 32'h0, 12'h800, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResult(0, 1'b1);
        applyStimulus(32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0);
        collectResult(0, 1'b1);
        applyStimulus(32'h8000000F, 32'h0, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResult(0, 1'b1);
        applyStimulus(32'h80000000, 32'd40, 12'h040, 1'b0, 1'b0, 1'b1, 1'b0);
        collectResult(0, 1'b1);
        applyStimulus(32'h00000001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b0, 1'b1);
        collectResult(0, 1'b1);

        // Stall in DONE, then hand off while a new request is already waiting.
        applyStimulus(32'h12345678, 32'h0, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResult(3, 1'b0);
        outReady = 1'b1;
        inValid = 1'b1;
        operandIn = 32'h12345678;
        rsVal = 32'h0;
        shiftOperand = 12'h420;
        isImmediate = 1'b0;
        signExtend = 1'b0;
        shiftByReg = 1'b0;
        carryIn = 1'b0;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("handoffValid", outValid, 0);
        checkOutput("handoffIdleReady", inReady, 1);
        @(posedge clk);
        #1;
        checkOutput("acceptNext", inReady, 0);
        inValid = 1'b0;
        refVal2(32'h12345678, 32'h0, 12'h420, 1'b0, 1'b0, 1'b0, 1'b0, pend.res, pend.cout, pend.lat);
        sbQueue.push_back(pend);
        collectResult(0, 1'b1);

        // Flush during the second SHIFT cycle of a 32-bit LSR.
        applyStimulus(32'hF0F0F0F0, 32'd32, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flushReady", inReady, 1);
        checkOutput("flushValid", outValid, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("flushNoValid", outValid, 0);
        end
        void'(sbQueue.pop_back());

        // Asynchronous reset while a result waits in DONE.
        applyStimulus(32'h8000000F, 32'h0, 12'h080, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResult(0, 1'b0);
        rstN = 1'b0;
        #2;
        checkOutput("asyncRstValid", outValid, 0);
        checkOutput("asyncRstResult", operandOut, 0);
        checkOutput("asyncRstCarry", carryOut, 0);
        checkOutput("asyncRstReady", inReady, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reRstReady", inReady, 1);

        for (int i = 0; i < 24; i++) begin
            randSel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: randRs = 32'd32;
                1: randRs = 32'($urandom_range(33, 255)) | ($urandom() & 32'hFFFFFF00);
                default: randRs = 32'($urandom_range(0, 40));
            endcase
            applyStimulus($urandom(), randRs, 12'($urandom()), randSel == 2'd1, randSel == 2'd0,
                          randSel == 2'd2, 1'($urandom()));
            collectResult($urandom_range(0, 2), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end
endmodule
